// File: rtl/fake_jpeg_stim_sig_if.sv
// Handshake and data bundle between a stimulus controller and the fake_jpeg netlist harness.
// The master side is the bench or controller; the slave side is the stimulus generator.
interface fake_jpeg_stim_sig_if #(
    parameter int N_IN  = 5,
    parameter int SIG_W = 16
);
    logic             start;
    logic [N_IN-1:0]  stim;
    logic             resp;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [7:0]       pat_count;

    modport master (
        output start, resp,
        input  stim, busy, done, signature, pat_count
    );

    modport slave (
        input  start, resp,
        output stim, busy, done, signature, pat_count
    );
endinterface

// File: rtl/fake_jpeg_stim_sig.sv
// LFSR pattern source and MISR response compactor for fake_jpeg 5-in/1-out netlists.
//  state   | meaning
//  IDLE    | stim=0, waiting for start
//  RUN     | one LFSR vector per cycle on stim
//  DRAIN   | wait RESP_LAT cycles for the last responses
//  DONE    | one-cycle done pulse, signature final
module fake_jpeg_stim_sig #(
    parameter int                N_IN      = 5,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED      = 8'h01,
    parameter int                SIG_W     = 16,
    parameter logic [SIG_W-1:0]  SIG_POLY  = 16'h1021,
    parameter int                PATTERNS  = 32,
    parameter int                RESP_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fake_jpeg_stim_sig_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF   = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [7:0]        PAT_LAST   = 8'(PATTERNS);
    localparam logic [2:0]        DRAIN_LOAD = 3'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

    state_t            state, state_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [N_IN-1:0]   stim_q;
    logic [7:0]        pat_count;
    logic [SIG_W-1:0]  sig;
    logic [2:0]        drain_cnt;
    logic              vld_now;
    logic              cap;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (pat_count == PAT_LAST) state_nxt = (RESP_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == 3'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_RUN) || (state == S_DRAIN);
        bus.done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED_EFF;
            stim_q    <= '0;
            pat_count <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    stim_q    <= SEED_EFF[N_IN-1:0];
                    lfsr      <= lfsr_step(SEED_EFF);
                    pat_count <= 8'd1;
                end
                S_RUN: if (pat_count == PAT_LAST) begin
                    stim_q    <= '0;
                    drain_cnt <= DRAIN_LOAD;
                end else begin
                    stim_q    <= lfsr[N_IN-1:0];
                    lfsr      <= lfsr_step(lfsr);
                    pat_count <= pat_count + 8'd1;
                end
                S_DRAIN: if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
                default: ;
            endcase
        end
    end

    // Valid travels alongside each vector so the MISR sees exactly PATTERNS responses.
    assign vld_now = (state == S_RUN);

    generate
        if (RESP_LAT == 0) begin : g_comb
            assign cap = vld_now;
        end else begin : g_pipe
            logic [RESP_LAT-1:0] vld_pipe;
            always_ff @(posedge clk) begin
                if (rst) vld_pipe <= '0;
                else     vld_pipe <= (vld_pipe << 1) | RESP_LAT'(vld_now);
            end
            assign cap = vld_pipe[RESP_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            sig <= '0;
        else if (state == S_IDLE && bus.start)
            sig <= '0;
        else if (cap)
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0)
                   ^ {{SIG_W-1{1'b0}}, bus.resp};
    end

    assign bus.stim      = stim_q;
    assign bus.signature = sig;
    assign bus.pat_count = pat_count;
endmodule

// File: tb/tb_fake_jpeg_stim_sig.sv
// Directed bench for fake_jpeg_stim_sig: sequence, signature, latency, start hold,
// mid-run reset and full-period LFSR run.
module tb_fake_jpeg_stim_sig;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fake_jpeg_stim_sig_if #(.N_IN(5), .SIG_W(16)) if_a ();
    fake_jpeg_stim_sig_if #(.N_IN(5), .SIG_W(16)) if_b ();
    fake_jpeg_stim_sig_if #(.N_IN(5), .SIG_W(16)) if_c ();
    fake_jpeg_stim_sig_if #(.N_IN(5), .SIG_W(16)) if_d ();

    fake_jpeg_stim_sig #(.PATTERNS(4))                u_a (.clk(clk), .rst(rst), .bus(if_a));
    fake_jpeg_stim_sig #(.PATTERNS(8), .RESP_LAT(0))  u_b (.clk(clk), .rst(rst), .bus(if_b));
    fake_jpeg_stim_sig #(.PATTERNS(8), .RESP_LAT(3))  u_c (.clk(clk), .rst(rst), .bus(if_c));
    fake_jpeg_stim_sig #(.SEED(8'h00), .PATTERNS(255)) u_d (.clk(clk), .rst(rst), .bus(if_d));

    // Stand-in for a generated netlist: arbitrary 5-input boolean function.
    function automatic logic netf(input logic [4:0] v);
        return (v[0] & v[3]) ^ v[2] ^ (v[1] | v[4]);
    endfunction

    function automatic logic [15:0] ref_sig(input logic [7:0] seed, input int n);
        logic [7:0]  l;
        logic [15:0] s;
        l = seed;
        s = 16'h0;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, netf(l[4:0])};
            l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
        end
        return s;
    endfunction

    assign if_b.resp = netf(if_b.stim);

    logic r1, r2, r3;
    always @(posedge clk) begin
        r1 <= netf(if_c.stim);
        r2 <= r1;
        r3 <= r2;
    end
    assign if_c.resp = r3;
    assign if_d.resp = 1'b0;

    task automatic test_reset();
        total++;
        if (if_a.stim !== 5'h0 || if_a.busy !== 1'b0 || if_a.done !== 1'b0 ||
            if_a.signature !== 16'h0 || if_a.pat_count !== 8'h0) begin
            bad++;
            $display("FAIL reset: stim=%h busy=%b done=%b sig=%h pat=%0d, want all zero",
                     if_a.stim, if_a.busy, if_a.done, if_a.signature, if_a.pat_count);
        end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_stim [7];
        logic       exp_busy, exp_done;
        exp_stim = '{5'h01, 5'h18, 5'h1C, 5'h0E, 5'h00, 5'h00, 5'h00};
        @(negedge clk);
        if_a.start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 1) if_a.start = 1'b0;
            exp_busy = (cyc <= 5);
            exp_done = (cyc == 6);
            total++;
            if (if_a.stim !== exp_stim[cyc-1] || if_a.busy !== exp_busy || if_a.done !== exp_done) begin
                bad++;
                $display("FAIL sequence cyc%0d: stim=%h busy=%b done=%b, want stim=%h busy=%b done=%b",
                         cyc, if_a.stim, if_a.busy, if_a.done, exp_stim[cyc-1], exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_signature(input logic rv, input logic [15:0] exp_sig);
        int          done_cyc;
        logic [15:0] got;
        done_cyc = 0;
        got = 16'h0;
        if_a.resp = rv;
        @(negedge clk);
        if_a.start = 1'b1;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) if_a.start = 1'b0;
            if (if_a.done) begin
                done_cyc = cyc;
                got = if_a.signature;
            end
        end
        total++;
        if (done_cyc != 6 || got !== exp_sig) begin
            bad++;
            $display("FAIL signature resp=%b: done_cyc=%0d sig=%h, want done_cyc=6 sig=%h",
                     rv, done_cyc, got, exp_sig);
        end
        @(negedge clk);
        total++;
        if (if_a.signature !== exp_sig || if_a.done !== 1'b0) begin
            bad++;
            $display("FAIL signature_hold: sig=%h done=%b, want sig=%h done=0",
                     if_a.signature, if_a.done, exp_sig);
        end
    endtask

    task automatic test_latency();
        int          done_b, done_c;
        logic [15:0] sig_b, sig_c, want;
        done_b = 0;
        done_c = 0;
        sig_b = 16'h0;
        sig_c = 16'h0;
        want = ref_sig(8'h01, 8);
        @(negedge clk);
        if_b.start = 1'b1;
        if_c.start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if_b.start = 1'b0;
                if_c.start = 1'b0;
            end
            if (if_b.done && done_b == 0) begin done_b = cyc; sig_b = if_b.signature; end
            if (if_c.done && done_c == 0) begin done_c = cyc; sig_c = if_c.signature; end
        end
        total++;
        if (done_b != 9 || sig_b !== want) begin
            bad++;
            $display("FAIL latency0: done_cyc=%0d sig=%h, want done_cyc=9 sig=%h", done_b, sig_b, want);
        end
        total++;
        if (done_c != 12 || sig_c !== want) begin
            bad++;
            $display("FAIL latency3: done_cyc=%0d sig=%h, want done_cyc=12 sig=%h", done_c, sig_c, want);
        end
    endtask

    task automatic test_start_held();
        int n_done, done_cyc;
        n_done = 0;
        done_cyc = 0;
        @(negedge clk);
        if_a.start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (if_a.done) begin n_done++; done_cyc = cyc; end
            if (cyc == 3) begin
                total++;
                if (if_a.pat_count !== 8'd3) begin
                    bad++;
                    $display("FAIL hold_pat: pat_count=%0d, want 3", if_a.pat_count);
                end
            end
            if (cyc == 7) begin
                total++;
                if (if_a.busy !== 1'b0 || if_a.stim !== 5'h0) begin
                    bad++;
                    $display("FAIL hold_idle: busy=%b stim=%h, want busy=0 stim=00", if_a.busy, if_a.stim);
                end
                if_a.start = 1'b0;
            end
        end
        total++;
        if (n_done != 1 || done_cyc != 6) begin
            bad++;
            $display("FAIL hold_done: pulses=%0d last_cyc=%0d, want pulses=1 cyc=6", n_done, done_cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        n_done = 0;
        if_a.resp = 1'b1;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        @(negedge clk);
        total++;
        if (if_a.busy !== 1'b1 || if_a.pat_count !== 8'd2) begin
            bad++;
            $display("FAIL midrst_pre: busy=%b pat=%0d, want busy=1 pat=2", if_a.busy, if_a.pat_count);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (if_a.busy !== 1'b0 || if_a.stim !== 5'h0 || if_a.signature !== 16'h0 ||
            if_a.done !== 1'b0 || if_a.pat_count !== 8'h0) begin
            bad++;
            $display("FAIL midrst_post: busy=%b stim=%h sig=%h done=%b pat=%0d, want all zero",
                     if_a.busy, if_a.stim, if_a.signature, if_a.done, if_a.pat_count);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (if_a.done) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL midrst_nodone: pulses=%0d, want 0", n_done);
        end
        test_sequence();
    endtask

    task automatic test_seed_zero();
        bit [255:0] seen;
        logic [7:0] m, cur;
        int         done_cyc, n_err;
        logic [7:0] pat_at_done;
        seen = '0;
        m = 8'h01;
        done_cyc = 0;
        n_err = 0;
        pat_at_done = 8'h0;
        @(negedge clk);
        if_d.start = 1'b1;
        for (int cyc = 1; cyc <= 270 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if_d.start = 1'b0;
                total++;
                if (if_d.stim !== 5'h01) begin
                    bad++;
                    $display("FAIL seed0_first: stim=%h, want 01", if_d.stim);
                end
            end
            if (cyc <= 255) begin
                cur = u_d.lfsr;
                if (if_d.stim !== m[4:0] || cur == 8'h0 || seen[cur]) n_err++;
                seen[cur] = 1'b1;
                m = (m >> 1) ^ (m[0] ? 8'hB8 : 8'h00);
            end
            if (if_d.done) begin
                done_cyc = cyc;
                pat_at_done = if_d.pat_count;
            end
        end
        total++;
        if (n_err != 0) begin
            bad++;
            $display("FAIL seed0_states: errors=%0d, want 0 (stim mismatch, zero or repeated state)", n_err);
        end
        total++;
        if (done_cyc != 257 || pat_at_done !== 8'd255) begin
            bad++;
            $display("FAIL seed0_done: done_cyc=%0d pat=%0d, want done_cyc=257 pat=255",
                     done_cyc, pat_at_done);
        end
    endtask

    initial begin
        if_a.start = 1'b0;
        if_a.resp  = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
        if_d.start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_sequence();
        test_signature(1'b0, 16'h0000);
        test_signature(1'b1, 16'h000F);
        test_latency();
        test_start_held();
        test_reset_mid_run();
        test_seed_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
